// File: rtl/lzss_decoder_if.sv
// lzss_decoder_if: codeword/result bundle for lzss_decoder.
//   master : codeword source / result sink (drives codeword, cw_valid, cw_done)
//   slave  : decoder side (drives busy, dout, dout_valid, dec_num, finish, err)
interface lzss_decoder_if;
  logic [10:0] codeword;
  logic        cw_valid;
  logic        cw_done;
  logic        busy;
  logic [31:0] dout;
  logic        dout_valid;
  logic [11:0] dec_num;
  logic        finish;
  logic        err;

  modport master (
    output codeword, cw_valid, cw_done,
    input  busy, dout, dout_valid, dec_num, finish, err
  );

  modport slave (
    input  codeword, cw_valid, cw_done,
    output busy, dout, dout_valid, dec_num, finish, err
  );
endinterface

// File: rtl/lzss_decoder.sv
// lzss_decoder: LZSS codeword decoder with a 128-byte sliding history.
// Codewords: literal {0, byte[7:0], 2'b00}, match {1, off[6:0], len[2:0]}
// (distance off+1, length len+2). Decoded bytes are packed MSB-first into
// 32-bit words; a trailing partial word is flushed zero-padded on cw_done.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - lzss_decoder_if.slave: codeword/cw_valid/cw_done in,
//           busy/dout/dout_valid/dec_num/finish/err out
// Optional macro LZSS_DEC_CHECK_EN: tracks history fill; a match reaching
// beyond written history sets sticky err and copies zero bytes instead.
module lzss_decoder (
  input  logic          clk,
  input  logic          reset,
  lzss_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COPY, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [6:0]  wptr_q, wptr_d;
  logic [6:0]  dist_q, dist_d;   // off+1, distance 128 wraps to 0 (same mod 128)
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] dout_q, dout_d;
  logic        dv_q, dv_d;
  logic [11:0] num_q, num_d;
  logic        fin_q, fin_d;

  logic [7:0]  hist [128];
  logic        accept;
  logic        byte_en;
  logic [7:0]  byte_val;
  logic [6:0]  rd_idx;
  logic [1:0]  unused_pad;

`ifdef LZSS_DEC_CHECK_EN
  logic [7:0]  fill_q, fill_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
`endif

  assign accept     = bus.cw_valid && !busy_q;
  assign rd_idx     = wptr_q - dist_q;
  assign unused_pad = bus.codeword[1:0];

  always_comb begin
    state_d  = state_q;
    dist_d   = dist_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    pcnt_d   = pcnt_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    num_d    = num_q;
    dv_d     = 1'b0;
    fin_d    = 1'b0;
    byte_en  = 1'b0;
    byte_val = '0;
`ifdef LZSS_DEC_CHECK_EN
    fill_d   = fill_q;
    zero_d   = zero_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.codeword[10]) begin
            byte_en  = 1'b1;
            byte_val = bus.codeword[9:2];
          end else begin
            dist_d  = bus.codeword[9:3] + 7'd1;
            cnt_d   = {1'b0, bus.codeword[2:0]} + 4'd2;
            state_d = COPY;
`ifdef LZSS_DEC_CHECK_EN
            // off+1 > fill  <=>  off >= fill
            zero_d = ({1'b0, bus.codeword[9:3]} >= fill_q);
            if ({1'b0, bus.codeword[9:3]} >= fill_q) err_d = 1'b1;
`endif
          end
        end else if (bus.cw_done) begin
          state_d = FLUSH;
        end
      end
      COPY: begin
        byte_en  = 1'b1;
        byte_val = hist[rd_idx];
`ifdef LZSS_DEC_CHECK_EN
        if (zero_q) byte_val = '0;
`endif
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      FLUSH: begin
        if (pcnt_q != 2'd0) begin
          dout_d = acc_q;
          dv_d   = 1'b1;
          num_d  = num_q + 12'd1;
          acc_d  = '0;
          pcnt_d = '0;
        end
        fin_d   = 1'b1;
        state_d = DONE;
      end
      default: ;
    endcase

    // Byte packing is shared by literal and copy paths; the accumulator is
    // cleared on each emit so a flushed partial word has zero low bytes.
    if (byte_en) begin
      wptr_d = wptr_q + 7'd1;
      pcnt_d = pcnt_q + 2'd1;
      case (pcnt_q)
        2'd0: acc_d[31:24] = byte_val;
        2'd1: acc_d[23:16] = byte_val;
        2'd2: acc_d[15:8]  = byte_val;
        default: begin
          dout_d = {acc_q[31:8], byte_val};
          dv_d   = 1'b1;
          num_d  = num_q + 12'd1;
          acc_d  = '0;
        end
      endcase
`ifdef LZSS_DEC_CHECK_EN
      if (fill_q != 8'd128) fill_d = fill_q + 8'd1;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      dist_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      pcnt_q  <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      num_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      dist_q  <= dist_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      pcnt_q  <= pcnt_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      num_q   <= num_d;
      fin_q   <= fin_d;
    end
  end

`ifdef LZSS_DEC_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      zero_q <= zero_d;
      err_q  <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // History is deliberately not reset.
  always_ff @(posedge clk) begin
    if (byte_en) hist[wptr_q] <= byte_val;
  end

  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.dec_num    = num_q;
  assign bus.finish     = fin_q;
endmodule

// File: tb/tb_lzss_decoder.sv
module tb_lzss_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  lzss_decoder_if bus();

  lzss_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    bit          rst;
    bit          v;
    logic [10:0] cw;
    bit          done;
    bit          e_busy;
    bit          e_dv;
    logic [31:0] e_dout;
    logic [11:0] e_num;
    bit          e_fin;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] lit(input logic [7:0] b);
    return {1'b0, b, 2'b00};
  endfunction

  function automatic vec_t mk(input bit rst, input bit v, input logic [10:0] cw,
                              input bit done, input bit eb, input bit edv,
                              input logic [31:0] ed, input logic [11:0] en,
                              input bit ef);
    vec_t r;
    r.rst = rst; r.v = v; r.cw = cw; r.done = done; r.e_busy = eb;
    r.e_dv = edv; r.e_dout = ed; r.e_num = en; r.e_fin = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle; inputs change 1ns after the edge and outputs are read there.
  task automatic step(input bit v, input logic [10:0] cw, input bit done);
    bus.cw_valid = v;
    bus.codeword = cw;
    bus.cw_done  = done;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    bus.cw_done  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [31:0] exp_err;

  initial begin
    bus.codeword = '0;
    bus.cw_valid = 1'b0;
    bus.cw_done  = 1'b0;
`ifdef LZSS_DEC_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif

    // rst v  cw           done busy dv dout          num    fin
    tbl.push_back(mk(1, 0, 11'h000, 0, 0, 0, 32'h0,        12'd0, 0));
    tbl.push_back(mk(0, 1, lit(8'h41), 0, 0, 0, 32'h0,      12'd0, 0));
    tbl.push_back(mk(0, 1, lit(8'h42), 0, 0, 0, 32'h0,      12'd0, 0));
    tbl.push_back(mk(0, 1, lit(8'h43), 0, 0, 0, 32'h0,      12'd0, 0));
    tbl.push_back(mk(0, 1, lit(8'h44), 0, 0, 1, 32'h41424344, 12'd1, 0));
    tbl.push_back(mk(0, 1, lit(8'h61), 0, 0, 0, 32'h41424344, 12'd1, 0));
    tbl.push_back(mk(0, 1, 11'h401,  0, 1, 0, 32'h41424344, 12'd1, 0));
    tbl.push_back(mk(0, 1, lit(8'h7F), 0, 1, 0, 32'h41424344, 12'd1, 0)); // ignored while busy
    tbl.push_back(mk(0, 0, 11'h000, 0, 1, 0, 32'h41424344, 12'd1, 0));
    tbl.push_back(mk(0, 0, 11'h000, 0, 0, 1, 32'h61616161, 12'd2, 0));
    tbl.push_back(mk(0, 0, 11'h000, 0, 0, 0, 32'h61616161, 12'd2, 0));
    tbl.push_back(mk(1, 0, 11'h000, 0, 0, 0, 32'h0,        12'd0, 0));
    tbl.push_back(mk(0, 1, lit(8'h41), 1, 0, 0, 32'h0,      12'd0, 0)); // valid beats done
    tbl.push_back(mk(0, 1, lit(8'h42), 1, 0, 0, 32'h0,      12'd0, 0));
    tbl.push_back(mk(0, 0, 11'h000, 1, 1, 0, 32'h0,        12'd0, 0));
    tbl.push_back(mk(0, 0, 11'h000, 1, 1, 1, 32'h41420000, 12'd1, 1));
    tbl.push_back(mk(0, 1, lit(8'h43), 1, 1, 0, 32'h41420000, 12'd1, 0)); // DONE ignores input
    tbl.push_back(mk(0, 0, 11'h000, 0, 1, 0, 32'h41420000, 12'd1, 0));
    tbl.push_back(mk(1, 0, 11'h000, 0, 0, 0, 32'h0,        12'd0, 0));
    tbl.push_back(mk(0, 0, 11'h000, 1, 1, 0, 32'h0,        12'd0, 0));
    tbl.push_back(mk(0, 0, 11'h000, 1, 1, 0, 32'h0,        12'd0, 1)); // empty flush
    tbl.push_back(mk(0, 0, 11'h000, 0, 1, 0, 32'h0,        12'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else step(tbl[i].v, tbl[i].cw, tbl[i].done);
      chk($sformatf("v%0d.busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("v%0d.dv", i), {31'd0, bus.dout_valid}, {31'd0, tbl[i].e_dv});
      chk($sformatf("v%0d.dout", i), bus.dout, tbl[i].e_dout);
      chk($sformatf("v%0d.num", i), {20'd0, bus.dec_num}, {20'd0, tbl[i].e_num});
      chk($sformatf("v%0d.fin", i), {31'd0, bus.finish}, {31'd0, tbl[i].e_fin});
      chk($sformatf("v%0d.err", i), {31'd0, bus.err}, 32'd0);
    end

    // History wrap: 130 literals, then dist 128 len 2 reads entries 2,3.
    do_reset();
    for (int i = 0; i < 130; i++) step(1'b1, lit(8'(i)), 1'b0);
    chk("wrap.num_pre", {20'd0, bus.dec_num}, 32'd32);
    step(1'b1, 11'h7F8, 1'b0);
    chk("wrap.busy0", {31'd0, bus.busy}, 32'd1);
    step(1'b0, 11'h000, 1'b0);
    chk("wrap.busy1", {31'd0, bus.busy}, 32'd1);
    step(1'b0, 11'h000, 1'b0);
    chk("wrap.busy2", {31'd0, bus.busy}, 32'd0);
    chk("wrap.dv", {31'd0, bus.dout_valid}, 32'd1);
    chk("wrap.dout", bus.dout, 32'h80810203);
    chk("wrap.num", {20'd0, bus.dec_num}, 32'd33);

    // Asynchronous reset in the middle of a length-9 copy.
    do_reset();
    step(1'b1, lit(8'h61), 1'b0);
    step(1'b1, 11'h407, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 11'h000, 1'b0);
    chk("mid.dout_pre", bus.dout, 32'h61616161);
    chk("mid.busy_pre", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid.busy", {31'd0, bus.busy}, 32'd0);
    chk("mid.dv", {31'd0, bus.dout_valid}, 32'd0);
    chk("mid.dout", bus.dout, 32'h0);
    chk("mid.num", {20'd0, bus.dec_num}, 32'd0);
    chk("mid.fin", {31'd0, bus.finish}, 32'd0);
    chk("mid.err", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, lit(8'h5A), 1'b0);
    step(1'b1, lit(8'h31), 1'b0);
    step(1'b1, lit(8'h32), 1'b0);
    step(1'b1, lit(8'h33), 1'b0);
    chk("mid.z_dv", {31'd0, bus.dout_valid}, 32'd1);
    chk("mid.z_dout", bus.dout, 32'h5A313233);
    chk("mid.z_num", {20'd0, bus.dec_num}, 32'd1);

    // Match reaching into unwritten history as the first codeword.
    do_reset();
    step(1'b1, 11'h408, 1'b0);
    chk("ill.err0", {31'd0, bus.err}, exp_err);
    step(1'b0, 11'h000, 1'b0);
    step(1'b0, 11'h000, 1'b0);
    chk("ill.busy", {31'd0, bus.busy}, 32'd0);
    step(1'b0, 11'h000, 1'b1);
    step(1'b0, 11'h000, 1'b1);
    chk("ill.dv", {31'd0, bus.dout_valid}, 32'd1);
    chk("ill.num", {20'd0, bus.dec_num}, 32'd1);
    chk("ill.fin", {31'd0, bus.finish}, 32'd1);
    chk("ill.err1", {31'd0, bus.err}, exp_err);
`ifdef LZSS_DEC_CHECK_EN
    chk("ill.dout", bus.dout, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
